// File: rtl/svv_status_coalescer.sv
// svv_status_coalescer
// Run-length coalescer that sits in front of the status value vector FIFO.
// It samples a stream of status words. A status that differs from the previous
// one pushes a new FIFO entry {status, 1}. A repeated status rewrites the
// newest FIFO entry through the FIFO set port with an incremented count.
// The producer is backpressured whenever a push is needed and the FIFO has no
// room for it.
//
// Optional feature: define SVV_COALESCE_TIMEOUT_EN to seal an open entry after
// TIMEOUT-1 consecutive idle cycles. The default build has no idle counter.

module svv_status_coalescer #(
    parameter int STATUS_W = 4,
    parameter int CNT_W    = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [STATUS_W-1:0]       status_i,
    input  logic                      status_valid_i,
    output logic                      status_ready_o,
    input  logic                      flush_i,
    input  logic                      fifo_full_i,
    input  logic                      fifo_valid_i,
    input  logic                      fifo_pull_i,
    output logic                      push_o,
    output logic [STATUS_W+CNT_W-1:0] value_o,
    output logic                      set_o,
    output logic [STATUS_W+CNT_W-1:0] set_value_o,
    output logic                      open_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // IDLE: no updatable entry; OPEN: the newest FIFO entry belongs to us
    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [STATUS_W-1:0]  last_status;
    logic [STATUS_W-1:0]  last_status_nxt;
    logic [CNT_W-1:0]     run_cnt;
    logic [CNT_W-1:0]     run_cnt_nxt;

    logic                 eff_open;
    logic                 coalesce;
    logic                 ready_int;
    logic                 accept;

`ifdef SVV_COALESCE_TIMEOUT_EN
    localparam int              IDLE_W      = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = '1;
    localparam logic [IDLE_W-1:0] IDLE_SEAL = IDLE_W'(TIMEOUT - 1);

    logic [IDLE_W-1:0]    idle_cnt;
    logic [IDLE_W-1:0]    idle_cnt_nxt;
`endif

    // Decide between coalescing and pushing, and drive the FIFO-facing outputs
    always_comb begin
        eff_open       = 1'b0;
        coalesce       = 1'b0;
        ready_int      = 1'b0;
        accept         = 1'b0;
        status_ready_o = 1'b0;
        push_o         = 1'b0;
        set_o          = 1'b0;
        open_o         = 1'b0;
        value_o        = {status_i, CNT_ONE};
        set_value_o    = {status_i, run_cnt + CNT_ONE};

        // An empty FIFO means our newest entry has been consumed, and a flush
        // seals it, so neither may be rewritten
        eff_open  = (state == OPEN) & fifo_valid_i & ~flush_i;
        coalesce  = eff_open & (status_i == last_status) & (run_cnt != CNT_MAX);

        // A set rewrites an existing entry and never needs free space
        ready_int = coalesce | ~fifo_full_i | fifo_pull_i;
        accept    = status_valid_i & ready_int & ~rst_i;

        status_ready_o = ready_int & ~rst_i;
        push_o         = accept & ~coalesce;
        set_o          = accept & coalesce;
        open_o         = eff_open & ~rst_i;
    end

    // Next-state computation for the run tracker
    always_comb begin
        state_nxt       = state;
        last_status_nxt = last_status;
        run_cnt_nxt     = run_cnt;
`ifdef SVV_COALESCE_TIMEOUT_EN
        idle_cnt_nxt    = idle_cnt;
`endif

        if (accept && coalesce) begin
            run_cnt_nxt = run_cnt + CNT_ONE;
            state_nxt   = OPEN;
        end else if (accept) begin
            last_status_nxt = status_i;
            run_cnt_nxt     = CNT_ONE;
            state_nxt       = OPEN;
        end else if (flush_i || ((state == OPEN) && !fifo_valid_i)) begin
            state_nxt = IDLE;
        end

`ifdef SVV_COALESCE_TIMEOUT_EN
        // Count idle cycles while open; seal the entry once the limit is reached
        if (accept) begin
            idle_cnt_nxt = '0;
        end else if (state == OPEN) begin
            if (idle_cnt != IDLE_MAX) begin
                idle_cnt_nxt = idle_cnt + IDLE_W'(1);
            end
            if (idle_cnt_nxt >= IDLE_SEAL) begin
                state_nxt = IDLE;
            end
        end
`endif
    end

    // State register with synchronous reset; the open entry is simply forgotten
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last_status <= '0;
            run_cnt     <= '0;
`ifdef SVV_COALESCE_TIMEOUT_EN
            idle_cnt    <= '0;
`endif
        end else begin
            state       <= state_nxt;
            last_status <= last_status_nxt;
            run_cnt     <= run_cnt_nxt;
`ifdef SVV_COALESCE_TIMEOUT_EN
            idle_cnt    <= idle_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_svv_status_coalescer.sv
// tb_svv_status_coalescer
// Directed bench for svv_status_coalescer with STATUS_W=4, CNT_W=4, TIMEOUT=4.
// Expected push/set events are queued by the stimulus task and popped by an
// independent monitor whenever the DUT asserts push_o or set_o.

module tb_svv_status_coalescer;

    localparam int STATUS_W = 4;
    localparam int CNT_W    = 4;
    localparam int VW       = STATUS_W + CNT_W;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_PUSH = 2'd1;
    localparam logic [1:0] K_SET  = 2'd2;

    typedef struct {
        logic [1:0]    kind;
        logic [VW-1:0] value;
        string         name;
    } exp_t;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic [STATUS_W-1:0] status_i = '0;
    logic                status_valid_i = 1'b0;
    logic                status_ready_o;
    logic                flush_i = 1'b0;
    logic                fifo_full_i = 1'b0;
    logic                fifo_valid_i = 1'b0;
    logic                fifo_pull_i = 1'b0;
    logic                push_o;
    logic [VW-1:0]       value_o;
    logic                set_o;
    logic [VW-1:0]       set_value_o;
    logic                open_o;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    svv_status_coalescer #(
        .STATUS_W(STATUS_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .status_i      (status_i),
        .status_valid_i(status_valid_i),
        .status_ready_o(status_ready_o),
        .flush_i       (flush_i),
        .fifo_full_i   (fifo_full_i),
        .fifo_valid_i  (fifo_valid_i),
        .fifo_pull_i   (fifo_pull_i),
        .push_o        (push_o),
        .value_o       (value_o),
        .set_o         (set_o),
        .set_value_o   (set_value_o),
        .open_o        (open_o)
    );

    // Free-running clock
    always #5 clk_i = ~clk_i;

    // Scoreboard monitor: compare every push/set the DUT presents against the queue
    always @(negedge clk_i) begin
        if (push_o || set_o) begin
            exp_t          e;
            logic [1:0]    act_kind;
            logic [VW-1:0] act_value;
            act_kind  = {set_o, push_o};
            act_value = push_o ? value_o : set_value_o;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_event: got kind=%0d value=%h, expected nothing", act_kind, act_value);
            end else begin
                e = sb.pop_front();
                if (act_kind !== e.kind || act_value !== e.value) begin
                    bad++;
                    $display("[TB] FAIL %s event: got kind=%0d value=%h, expected kind=%0d value=%h",
                             e.name, act_kind, act_value, e.kind, e.value);
                end
            end
        end
    end

    // Compare the per-cycle handshake and open flag against the vector's expectation
    task automatic checkOutput(input string name, input logic exp_ready,
                               input logic [1:0] exp_kind, input int exp_open);
        logic [1:0] act_kind;
        act_kind = {set_o, push_o};
        total++;
        if (status_ready_o !== exp_ready) begin
            bad++;
            $display("[TB] FAIL %s ready: got %0b expected %0b", name, status_ready_o, exp_ready);
        end
        total++;
        if (act_kind !== exp_kind) begin
            bad++;
            $display("[TB] FAIL %s kind: got %0d expected %0d", name, act_kind, exp_kind);
        end
        if (exp_open >= 0) begin
            total++;
            if (open_o !== exp_open[0]) begin
                bad++;
                $display("[TB] FAIL %s open: got %0b expected %0b", name, open_o, exp_open[0]);
            end
        end
    endtask

    // Drive one cycle of inputs, queue the expected event, check, then advance
    task automatic applyStimulus(input string name, input logic v, input logic [STATUS_W-1:0] s,
                                 input logic fl, input logic full, input logic fv, input logic pull,
                                 input logic exp_ready, input logic [1:0] exp_kind,
                                 input logic [VW-1:0] exp_value, input int exp_open);
        exp_t e;
        status_valid_i = v;
        status_i       = s;
        flush_i        = fl;
        fifo_full_i    = full;
        fifo_valid_i   = fv;
        fifo_pull_i    = pull;
        if (exp_kind != K_NONE) begin
            e.kind  = exp_kind;
            e.value = exp_value;
            e.name  = name;
            sb.push_back(e);
        end
        @(negedge clk_i);
        checkOutput(name, exp_ready, exp_kind, exp_open);
        @(posedge clk_i);
        #1;
    endtask

    // Directed scenario list
    initial begin
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        applyStimulus("reset_a", 1, 4'd3, 0, 0, 0, 0, 0, K_NONE, 8'h00, 0);
        applyStimulus("reset_b", 1, 4'd3, 0, 0, 0, 0, 0, K_NONE, 8'h00, 0);
        rst_i = 1'b0;
        applyStimulus("post_reset_idle", 0, 4'd0, 0, 0, 0, 0, 1, K_NONE, 8'h00, 0);

        applyStimulus("t1_push3", 1, 4'd3, 0, 0, 0, 0, 1, K_PUSH, 8'h31, 0);
        applyStimulus("t1_set32", 1, 4'd3, 0, 0, 1, 0, 1, K_SET,  8'h32, 1);
        applyStimulus("t1_set33", 1, 4'd3, 0, 0, 1, 0, 1, K_SET,  8'h33, 1);

        applyStimulus("t2_push5", 1, 4'd5, 0, 0, 1, 0, 1, K_PUSH, 8'h51, 1);
        applyStimulus("t2_set52", 1, 4'd5, 0, 0, 1, 0, 1, K_SET,  8'h52, 1);

        applyStimulus("t3_push7", 1, 4'd7, 0, 0, 1, 0, 1, K_PUSH, 8'h71, 1);
        for (int i = 2; i <= 15; i++) begin
            applyStimulus($sformatf("t3_set7_%0d", i), 1, 4'd7, 0, 0, 1, 0, 1, K_SET, {4'd7, 4'(i)}, 1);
        end
        applyStimulus("t3_saturate_push", 1, 4'd7, 0, 0, 1, 0, 1, K_PUSH, 8'h71, 1);
        applyStimulus("t3_after_sat_set", 1, 4'd7, 0, 0, 1, 0, 1, K_SET,  8'h72, 1);

        applyStimulus("t4_full_block_a", 1, 4'd9, 0, 1, 1, 0, 0, K_NONE, 8'h00, 1);
        applyStimulus("t4_full_block_b", 1, 4'd9, 0, 1, 1, 0, 0, K_NONE, 8'h00, 1);
        applyStimulus("t4_full_pull",    1, 4'd9, 0, 1, 1, 1, 1, K_PUSH, 8'h91, 1);
        applyStimulus("t4_full_set",     1, 4'd9, 0, 1, 1, 0, 1, K_SET,  8'h92, 1);

        applyStimulus("t5_push2",          1, 4'd2, 0, 0, 1, 0, 1, K_PUSH, 8'h21, 1);
        applyStimulus("t5_consumed_push",  1, 4'd2, 0, 0, 0, 0, 1, K_PUSH, 8'h21, 0);
        applyStimulus("t5_flush_sample",   1, 4'd2, 1, 0, 1, 0, 1, K_PUSH, 8'h21, 0);
        applyStimulus("t5_set_after",      1, 4'd2, 0, 0, 1, 0, 1, K_SET,  8'h22, 1);
        applyStimulus("t5_flush_only",     0, 4'd2, 1, 0, 1, 0, 1, K_NONE, 8'h00, 0);
        applyStimulus("t5_idle_sealed",    0, 4'd2, 0, 0, 1, 0, 1, K_NONE, 8'h00, 0);
        applyStimulus("t5_push_after_fl",  1, 4'd2, 0, 0, 1, 0, 1, K_PUSH, 8'h21, 0);
        applyStimulus("t5_set_with_pull",  1, 4'd2, 0, 0, 1, 1, 1, K_SET,  8'h22, 1);
        applyStimulus("t5_emptied",        0, 4'd2, 0, 0, 0, 0, 1, K_NONE, 8'h00, 0);
        applyStimulus("t5_push_empty",     1, 4'd2, 0, 0, 0, 0, 1, K_PUSH, 8'h21, 0);

        applyStimulus("t7_push4", 1, 4'd4, 0, 0, 1, 0, 1, K_PUSH, 8'h41, 1);
        rst_i = 1'b1;
        applyStimulus("t7_reset", 1, 4'd4, 0, 0, 1, 0, 0, K_NONE, 8'h00, 0);
        rst_i = 1'b0;
        applyStimulus("t7_push_after_rst", 1, 4'd4, 0, 0, 1, 0, 1, K_PUSH, 8'h41, 0);

        applyStimulus("t6_push6", 1, 4'd6, 0, 0, 1, 0, 1, K_PUSH, 8'h61, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("t6_idle_%0d", i), 0, 4'd6, 0, 0, 1, 0, 1, K_NONE, 8'h00, -1);
        end
`ifdef SVV_COALESCE_TIMEOUT_EN
        applyStimulus("t6_timeout_push", 1, 4'd6, 0, 0, 1, 0, 1, K_PUSH, 8'h61, 0);
`else
        applyStimulus("t6_no_timeout_set", 1, 4'd6, 0, 0, 1, 0, 1, K_SET, 8'h62, 1);
`endif

        status_valid_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
